mem_port_seq: RTL and testbench

MEM_PORT_SEQ -- requirements
Module: mem_port_seq

---
 rtl/mem_port_seq_pkg.sv | 48 ++++
 rtl/mem_port_seq_load_ext.sv | 24 ++
 rtl/mem_port_seq.sv | 203 ++++++++++++++++++++
 tb/tb_mem_port_seq.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_seq_pkg.sv
// rtl/mem_port_seq_pkg.sv - shared state, byte-count and ls_type encodings for mem_port_seq
package mem_port_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_STORE = 2'd3
    } state_t;

    // Load/store width encodings (funct3 style)
    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LW  = 3'b010;
    localparam logic [2:0] LS_LBU = 3'b100;
    localparam logic [2:0] LS_LHU = 3'b101;
    localparam logic [2:0] LS_SB  = 3'b000;
    localparam logic [2:0] LS_SH  = 3'b001;
    localparam logic [2:0] LS_SW  = 3'b010;

    // Bytes moved per access
    localparam logic [2:0] NB_BYTE = 3'd1;
    localparam logic [2:0] NB_HALF = 3'd2;
    localparam logic [2:0] NB_WORD = 3'd4;

    // Number of serial bytes needed for a load or store of the given type
    function automatic logic [2:0] byte_count(input logic is_store, input logic [2:0] t);
        logic [2:0] n;
        n = NB_WORD;
        if (is_store) begin
            case (t)
                LS_SB:   n = NB_BYTE;
                LS_SH:   n = NB_HALF;
                LS_SW:   n = NB_WORD;
                default: n = NB_WORD;
            endcase
        end else begin
            case (t)
                LS_LB, LS_LBU: n = NB_BYTE;
                LS_LH, LS_LHU: n = NB_HALF;
                LS_LW:         n = NB_WORD;
                default:       n = NB_WORD;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/mem_port_seq_load_ext.sv
// rtl/mem_port_seq_load_ext.sv - combinational sign/zero extension of an assembled load word
module load_ext
    import mem_port_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [2:0]        ls_type,
    output logic [DATA_W-1:0] ext
);

    // Pick extension from the load type; word loads pass through
    always_comb begin
        ext = raw;
        case (ls_type)
            LS_LB:   ext = {{(DATA_W-8){raw[7]}}, raw[7:0]};
            LS_LH:   ext = {{(DATA_W-16){raw[15]}}, raw[15:0]};
            LS_LBU:  ext = {{(DATA_W-8){1'b0}}, raw[7:0]};
            LS_LHU:  ext = {{(DATA_W-16){1'b0}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_port_seq.sv
// rtl/mem_port_seq.sv - byte-serial fetch/load/store sequencer (optional ARB_ROUND_ROBIN_EN arbitration)
module mem_port_seq
    import mem_port_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_inst,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [2:0]        ls_type,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    input  logic              flush,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    localparam int NLANE = DATA_W / 8;

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nxt;
    logic [2:0]        nbytes;
    logic [2:0]        ltype;
    logic [DATA_W-1:0] dbuf;
    logic [DATA_W-1:0] asm_buf;
    logic [DATA_W-1:0] ext_data;
    logic [7:0]        sbyte_nxt;
    logic              accept_ok;
    logic              grant_ls;
    logic              grant_if;

    assign cnt_nxt = cnt + 3'd1;

    // Acceptance is blocked by flush and during the done-pulse cycle so a level-held request is not re-taken
    assign accept_ok = (state == ST_IDLE) && !flush && !if_done && !ls_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ls;

    // On a tie, serve whichever requester was not served last
    always_comb begin
        grant_ls = accept_ok && ls_req && (!if_req || !last_ls);
        grant_if = accept_ok && if_req && !grant_ls;
    end

    // Remember who was served last; starts as "fetch"
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_ls <= 1'b0;
        end else if (rdy) begin
            if (grant_ls) begin
                last_ls <= 1'b1;
            end else if (grant_if) begin
                last_ls <= 1'b0;
            end
        end
    end
`else
    // Load/store always wins over fetch
    always_comb begin
        grant_ls = accept_ok && ls_req;
        grant_if = accept_ok && if_req && !ls_req;
    end
`endif

    // Merge the byte arriving this cycle into its lane of the read buffer
    always_comb begin
        asm_buf = dbuf;
        for (int i = 0; i < NLANE; i++) begin
            if (cnt == 3'(i + 1)) begin
                asm_buf[8*i +: 8] = mem_din;
            end
        end
    end

    // Next store byte to present on mem_dout
    always_comb begin
        sbyte_nxt = 8'h00;
        for (int i = 0; i < NLANE; i++) begin
            if (cnt_nxt == 3'(i)) begin
                sbyte_nxt = dbuf[8*i +: 8];
            end
        end
    end

    load_ext #(
        .DATA_W(DATA_W)
    ) u_load_ext (
        .raw    (asm_buf),
        .ls_type(ltype),
        .ext    (ext_data)
    );

    // Sequencer FSM with registered memory-port and completion outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 3'd0;
            nbytes   <= 3'd0;
            ltype    <= 3'd0;
            dbuf     <= '0;
            if_done  <= 1'b0;
            if_inst  <= '0;
            ls_done  <= 1'b0;
            ls_rdata <= '0;
            mem_dout <= 8'h00;
            mem_a    <= '0;
            mem_wr   <= 1'b0;
        end else if (rdy) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mem_a    <= '0;
                    mem_wr   <= 1'b0;
                    mem_dout <= 8'h00;
                    cnt      <= 3'd0;
                    if (grant_ls) begin
                        nbytes <= byte_count(ls_wr, ls_type);
                        ltype  <= ls_type;
                        mem_a  <= ls_addr;
                        if (ls_wr) begin
                            state    <= ST_STORE;
                            dbuf     <= ls_wdata;
                            mem_wr   <= 1'b1;
                            mem_dout <= ls_wdata[7:0];
                        end else begin
                            state <= ST_LOAD;
                            dbuf  <= '0;
                        end
                    end else if (grant_if) begin
                        state  <= ST_FETCH;
                        nbytes <= NB_WORD;
                        ltype  <= LS_LW;
                        mem_a  <= if_addr;
                        dbuf   <= '0;
                    end
                end
                ST_FETCH, ST_LOAD: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        cnt   <= 3'd0;
                        dbuf  <= '0;
                        mem_a <= '0;
                    end else if (cnt == nbytes) begin
                        state <= ST_IDLE;
                        cnt   <= 3'd0;
                        dbuf  <= '0;
                        mem_a <= '0;
                        if (state == ST_FETCH) begin
                            if_done <= 1'b1;
                            if_inst <= asm_buf;
                        end else begin
                            ls_done  <= 1'b1;
                            ls_rdata <= ext_data;
                        end
                    end else begin
                        dbuf <= asm_buf;
                        cnt  <= cnt_nxt;
                        // Stop driving an address once the last byte has been requested
                        if (cnt_nxt < nbytes) begin
                            mem_a <= mem_a + ADDR_W'(1);
                        end else begin
                            mem_a <= '0;
                        end
                    end
                end
                ST_STORE: begin
                    // Stores ignore flush: once started they always complete
                    if (cnt_nxt < nbytes) begin
                        cnt      <= cnt_nxt;
                        mem_a    <= mem_a + ADDR_W'(1);
                        mem_dout <= sbyte_nxt;
                    end else begin
                        state    <= ST_IDLE;
                        cnt      <= 3'd0;
                        dbuf     <= '0;
                        mem_a    <= '0;
                        mem_wr   <= 1'b0;
                        mem_dout <= 8'h00;
                        ls_done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_seq.sv
// tb/tb_mem_port_seq.sv - scoreboard testbench for mem_port_seq
module tb_mem_port_seq;
    import mem_port_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_done;
    logic [31:0] if_inst;
    logic        ls_req = 1'b0;
    logic        ls_wr = 1'b0;
    logic [2:0]  ls_type = 3'd0;
    logic [31:0] ls_addr = 32'h0;
    logic [31:0] ls_wdata = 32'h0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        flush = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:4095];
    logic [31:0] exp_q[$];
    logic [39:0] wr_log[$];
    logic [39:0] exp_wr_q[$];

    mem_port_seq #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdy     (rdy),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_done (if_done),
        .if_inst (if_inst),
        .ls_req  (ls_req),
        .ls_wr   (ls_wr),
        .ls_type (ls_type),
        .ls_addr (ls_addr),
        .ls_wdata(ls_wdata),
        .ls_done (ls_done),
        .ls_rdata(ls_rdata),
        .flush   (flush),
        .mem_din (mem_din),
        .mem_dout(mem_dout),
        .mem_a   (mem_a),
        .mem_wr  (mem_wr)
    );

    always #5 clk = ~clk;

    // Byte memory: one-cycle read latency, frozen together with the rest of the system when rdy is low
    always @(posedge clk) begin
        if (rdy) begin
            mem_din <= mem[mem_a[11:0]];
            if (mem_wr) begin
                mem[mem_a[11:0]] <= mem_dout;
                wr_log.push_back({mem_a, mem_dout});
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a);
        logic [31:0] w;
        w = {mem[12'(a + 32'd3)], mem[12'(a + 32'd2)], mem[12'(a + 32'd1)], mem[a[11:0]]};
        case (t)
            LS_LB:   return {{24{w[7]}}, w[7:0]};
            LS_LH:   return {{16{w[15]}}, w[15:0]};
            LS_LBU:  return {24'h0, w[7:0]};
            LS_LHU:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic run_ls(input logic wr, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input int flush_cyc, input string name);
        int n;
        int cyc;
        logic seen;
        logic [39:0] got;
        logic [39:0] want;
        logic [31:0] wdat;
        n = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
        if (wr) begin
            for (int i = 0; i < n; i++) exp_wr_q.push_back({a + 32'(i), wd[8*i +: 8]});
        end else begin
            exp_q.push_back(model_load(t, a));
        end
        @(negedge clk);
        ls_req = 1'b1; ls_wr = wr; ls_type = t; ls_addr = a; ls_wdata = wd;
        @(negedge clk);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (cyc < n) begin
                checks++;
                if (mem_a !== a + 32'(cyc) || mem_wr !== wr) begin
                    errors++;
                    $display("FAIL %s port cycle %0d: mem_a/mem_wr %h/%b, required %h/%b",
                             name, cyc, mem_a, mem_wr, a + 32'(cyc), wr);
                end
            end
            if (ls_done === 1'b1) begin
                seen = 1'b1;
                ls_req = 1'b0;
                flush = 1'b0;
                checks++;
                if (cyc != (wr ? n : n + 1)) begin
                    errors++;
                    $display("FAIL %s latency: done at cycle %0d, required %0d", name, cyc, wr ? n : n + 1);
                end
                if (!wr) begin
                    wdat = exp_q.pop_front();
                    checks++;
                    if (ls_rdata !== wdat) begin
                        errors++;
                        $display("FAIL %s rdata: %h, required %h", name, ls_rdata, wdat);
                    end
                end
            end else begin
                if (cyc == flush_cyc) flush = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no ls_done within 20 cycles, required one", name);
            ls_req = 1'b0;
            flush = 1'b0;
            exp_q.delete();
        end
        while (wr_log.size() > 0) begin
            got = wr_log.pop_front();
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL %s write: unexpected %h, required none", name, got);
            end else begin
                want = exp_wr_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s write: %h, required %h", name, got, want);
                end
            end
        end
        checks++;
        if (exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL %s writes missing: %0d left, required 0", name, exp_wr_q.size());
            exp_wr_q.delete();
        end
    endtask

    task automatic run_fetch(input logic [31:0] a, input string name);
        int cyc;
        logic seen;
        logic [31:0] want;
        exp_q.push_back(model_load(LS_LW, a));
        @(negedge clk);
        if_req = 1'b1; if_addr = a;
        @(negedge clk);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (if_done === 1'b1) begin
                seen = 1'b1;
                if_req = 1'b0;
                want = exp_q.pop_front();
                checks++;
                if (cyc != 5 || if_inst !== want) begin
                    errors++;
                    $display("FAIL %s: done cycle %0d inst %h, required cycle 5 inst %h", name, cyc, if_inst, want);
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no if_done, required one", name);
            if_req = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_a, mem_wr, mem_dout, if_done, ls_done, if_inst, ls_rdata} !== 107'd0) begin
            errors++;
            $display("FAIL reset outputs: mem_a %h wr %b dout %h done %b/%b inst %h rdata %h, required all 0",
                     mem_a, mem_wr, mem_dout, if_done, ls_done, if_inst, ls_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_priority;
        int cyc;
        logic served_ls;
        logic want_ls;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h1000;
            ls_req = 1'b1; ls_wr = 1'b0; ls_type = LS_LW; ls_addr = 32'h300;
            cyc = 0;
            while (!(if_done || ls_done) && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            served_ls = ls_done;
            if_req = 1'b0;
            ls_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            want_ls = (r == 0);
`else
            want_ls = 1'b1;
`endif
            checks++;
            if (cyc >= 20 || served_ls !== want_ls) begin
                errors++;
                $display("FAIL priority round %0d: served_ls %b after %0d cycles, required %b", r, served_ls, cyc, want_ls);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_load;
        run_ls(1'b0, LS_LB,  32'h100, 32'h0, -1, "lb");
        run_ls(1'b0, LS_LBU, 32'h100, 32'h0, -1, "lbu");
        run_ls(1'b0, LS_LH,  32'h104, 32'h0, -1, "lh");
        run_ls(1'b0, LS_LHU, 32'h104, 32'h0, -1, "lhu");
        run_ls(1'b0, LS_LW,  32'h104, 32'h0, -1, "lw");
        checks++;
        if (model_load(LS_LB, 32'h100) !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb model: %h, required ffffff80", model_load(LS_LB, 32'h100));
        end
    endtask

    task automatic test_store;
        logic [31:0] w;
        run_ls(1'b1, LS_SW, 32'h200, 32'hDEADBEEF, -1, "sw");
        w = {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]};
        checks++;
        if (w !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw memory: %h, required deadbeef", w);
        end
        run_ls(1'b0, LS_LW, 32'h200, 32'h0, -1, "sw_readback");
        run_ls(1'b1, LS_SB, 32'h208, 32'h12345677, -1, "sb");
        run_ls(1'b1, LS_SH, 32'h20C, 32'h9876CAFE, -1, "sh");
        run_ls(1'b0, LS_LHU, 32'h20C, 32'h0, -1, "sh_readback");
    endtask

    task automatic test_wrap;
        run_ls(1'b0, LS_LW, 32'hFFFFFFFE, 32'h0, -1, "wrap_lw");
    endtask

    task automatic test_flush_fetch;
        logic done_seen;
        logic wr_seen;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h1000;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_a !== 32'h1002) begin
            errors++;
            $display("FAIL flush_fetch cycle2 mem_a: %h, required 00001002", mem_a);
        end
        flush = 1'b1;
        if_req = 1'b0;
        done_seen = 1'b0;
        wr_seen = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (mem_a !== 32'h0) begin
            errors++;
            $display("FAIL flush_fetch idle mem_a: %h, required 00000000", mem_a);
        end
        for (int i = 0; i < 8; i++) begin
            if (if_done === 1'b1) done_seen = 1'b1;
            if (mem_wr !== 1'b0) wr_seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (done_seen !== 1'b0 || wr_seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_fetch: if_done seen %b mem_wr seen %b, required 0/0", done_seen, wr_seen);
        end
        run_fetch(32'h1000, "fetch_after_flush");
    endtask

    task automatic test_flush_store;
        run_ls(1'b1, LS_SH, 32'h400, 32'h00005A3C, 1, "sh_flush");
        run_ls(1'b0, LS_LH, 32'h400, 32'h0, -1, "sh_flush_readback");
    endtask

    task automatic test_rdy;
        int cyc;
        logic seen;
        logic [31:0] want;
        exp_q.push_back(model_load(LS_LW, 32'h500));
        @(negedge clk);
        ls_req = 1'b1; ls_wr = 1'b0; ls_type = LS_LW; ls_addr = 32'h500;
        @(negedge clk);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 30) begin
            if (cyc >= 1 && cyc <= 4) begin
                checks++;
                if (mem_a !== 32'h501) begin
                    errors++;
                    $display("FAIL rdy frozen mem_a cycle %0d: %h, required 00000501", cyc, mem_a);
                end
            end
            if (ls_done === 1'b1) begin
                seen = 1'b1;
                ls_req = 1'b0;
                want = exp_q.pop_front();
                checks++;
                if (cyc != 8 || ls_rdata !== want) begin
                    errors++;
                    $display("FAIL rdy lw: done cycle %0d data %h, required cycle 8 data %h", cyc, ls_rdata, want);
                end
            end else begin
                if (cyc == 1) rdy = 1'b0;
                if (cyc == 4) rdy = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL rdy timeout: no ls_done, required one");
            ls_req = 1'b0;
            rdy = 1'b1;
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_store;
        logic [39:0] got;
        logic [39:0] want;
        exp_wr_q.push_back({32'h600, 8'h22});
        exp_wr_q.push_back({32'h601, 8'h11});
        @(negedge clk);
        ls_req = 1'b1; ls_wr = 1'b1; ls_type = LS_SW; ls_addr = 32'h600; ls_wdata = 32'hA5A51122;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h601 || mem_dout !== 8'h11) begin
            errors++;
            $display("FAIL rst_store byte1: wr %b a %h dout %h, required 1 00000601 11", mem_wr, mem_a, mem_dout);
        end
        rst_n = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_a, mem_wr, mem_dout, if_done, ls_done, if_inst, ls_rdata} !== 107'd0) begin
            errors++;
            $display("FAIL rst_store outputs: mem_a %h wr %b dout %h done %b/%b, required all 0",
                     mem_a, mem_wr, mem_dout, if_done, ls_done);
        end
        rst_n = 1'b1;
        while (wr_log.size() > 0) begin
            got = wr_log.pop_front();
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL rst_store write: unexpected %h, required none", got);
            end else begin
                want = exp_wr_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL rst_store write: %h, required %h", got, want);
                end
            end
        end
        checks++;
        if (exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL rst_store writes missing: %0d left, required 0", exp_wr_q.size());
            exp_wr_q.delete();
        end
        run_fetch(32'h600, "fetch_after_reset");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 11);
        mem[12'h100] = 8'h80;
        mem[12'h104] = 8'h01;
        mem[12'h105] = 8'h80;
        test_reset;
        test_priority;
        test_load;
        test_store;
        test_wrap;
        test_flush_fetch;
        test_flush_store;
        test_rdy;
        test_reset_mid_store;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
